// File: rtl/div_pwm_pkg.sv
// Shared defaults and helpers for the div_clk-driven PWM generator.
package div_pwm_pkg;

   localparam int CNT_W_DEF  = 8;
   localparam int PERIOD_DEF = 10;

   function automatic int clamp_duty(input int duty, input int period);
      return (duty > period) ? period : duty;
   endfunction

   function automatic bit period_ok(input int cnt_w, input int period);
      return (period >= 2) && (period < (1 << cnt_w));
   endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for an already-synchronous level.
module rise_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   input  logic en,
   output logic step
);

   logic sig_q;

   // Reset high so a level that is already high at release is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sig_q <= 1'b1;
      else       sig_q <= sig;
   end

   assign step = en & sig & ~sig_q;

endmodule

// File: rtl/div_pwm_gen.sv
// PWM generator clocked by rising edges of the divider output level.
module div_pwm_gen
   import div_pwm_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PERIOD = PERIOD_DEF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             div_clk,
   input  logic             en,
   input  logic [CNT_W-1:0] duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             period_start,
   output logic [CNT_W-1:0] duty_active
);

   if (!period_ok(CNT_W, PERIOD)) begin : g_bad_period
      $error("div_pwm_gen: PERIOD out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic             step;
   logic             wrap;
   logic             accept;
   logic             pending;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] cnt_n;
   logic [CNT_W-1:0] duty_n;
   logic [CNT_W-1:0] shadow_n;
   logic             pending_n;
   logic             ps_n;
   logic             pwm_n;

   rise_edge_det u_edge (
      .clk   (clk_in),
      .reset (reset),
      .sig   (div_clk),
      .en    (en),
      .step  (step)
   );

   assign duty_ready = ~pending;
   assign accept     = duty_valid & duty_ready;
   assign wrap       = step & (cnt == LAST);

   // Pending is applied before the accept, so an accept in a wrap cycle waits.
   always_comb begin
      cnt_n     = cnt;
      duty_n    = duty_active;
      shadow_n  = shadow;
      pending_n = pending;
      ps_n      = 1'b0;
      if (!en) begin
         cnt_n = '0;
         if (pending) begin
            duty_n    = shadow;
            pending_n = 1'b0;
         end
      end else if (step) begin
         cnt_n = wrap ? '0 : cnt + 1'b1;
         if (wrap) begin
            ps_n = 1'b1;
            if (pending) begin
               duty_n    = shadow;
               pending_n = 1'b0;
            end
         end
      end
      if (accept) begin
         shadow_n  = CNT_W'(clamp_duty(int'(duty_in), PERIOD));
         pending_n = 1'b1;
      end
      pwm_n = en & (cnt_n < duty_n);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         duty_active  <= '0;
         shadow       <= '0;
         pending      <= 1'b0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt_n;
         duty_active  <= duty_n;
         shadow       <= shadow_n;
         pending      <= pending_n;
         pwm_out      <= pwm_n;
         period_start <= ps_n;
      end
   end

endmodule

// File: tb/tb_div_pwm_gen.sv
// Scoreboard bench for div_pwm_gen with PERIOD=10, CNT_W=8.
module tb_div_pwm_gen;

   localparam int P = 10;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       div_clk;
   logic       en;
   logic [7:0] duty_in;
   logic       duty_valid;
   logic       duty_ready;
   logic       pwm_out;
   logic       period_start;
   logic [7:0] duty_active;

   div_pwm_gen #(.CNT_W(8), .PERIOD(P)) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .div_clk      (div_clk),
      .en           (en),
      .duty_in      (duty_in),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty_active  (duty_active)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int         due;
      string      tag;
      logic       pwm;
      logic       ps;
      logic [7:0] duty;
      logic       rdy;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   ps_seen = 0;

   int e_cnt = 0;
   int e_duty = 0;
   int e_shadow = 0;
   bit e_pend = 0;

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic push(input string tag, input int dly, input bit ps);
      exp_t e;
      e.due  = cyc + dly;
      e.tag  = tag;
      e.pwm  = en && (e_cnt < e_duty);
      e.ps   = ps;
      e.duty = 8'(e_duty);
      e.rdy  = !e_pend;
      sb.push_back(e);
   endtask

   always @(posedge clk_in) begin
      cyc = cyc + 1;
      #1;
      if (period_start === 1'b1) ps_seen = ps_seen + 1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         check_eq({mon_e.tag, "_pwm"}, 32'(pwm_out), 32'(mon_e.pwm));
         check_eq({mon_e.tag, "_ps"}, 32'(period_start), 32'(mon_e.ps));
         check_eq({mon_e.tag, "_duty"}, 32'(duty_active), 32'(mon_e.duty));
         check_eq({mon_e.tag, "_rdy"}, 32'(duty_ready), 32'(mon_e.rdy));
      end
   end

   // One div_clk rise, optionally with a duty offered in the step cycle.
   task automatic div_rise(input string tag, input int acc = -1);
      bit wrap;
      @(negedge clk_in);
      div_clk = 1'b0;
      @(negedge clk_in);
      div_clk = 1'b1;
      if (acc >= 0) begin
         duty_in    = 8'(acc);
         duty_valid = 1'b1;
      end
      wrap = (e_cnt == P - 1);
      if (wrap) begin
         e_cnt = 0;
         if (e_pend) begin
            e_duty = e_shadow;
            e_pend = 0;
         end
      end else begin
         e_cnt++;
      end
      if (acc >= 0) begin
         e_shadow = (acc > P) ? P : acc;
         e_pend   = 1;
      end
      push(tag, 1, wrap);
      @(negedge clk_in);
      duty_valid = 1'b0;
      push(tag, 1, 1'b0);
   endtask

   task automatic accept(input string tag, input int d);
      @(negedge clk_in);
      duty_in    = 8'(d);
      duty_valid = 1'b1;
      e_shadow   = (d > P) ? P : d;
      e_pend     = 1;
      push(tag, 1, 1'b0);
      @(negedge clk_in);
      duty_valid = 1'b0;
      duty_in    = 8'($urandom);
      if (!en) begin
         e_duty = e_shadow;
         e_pend = 0;
      end
      push(tag, 1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      en         = 1'b0;
      div_clk    = 1'b1;
      duty_valid = 1'b0;
      duty_in    = '0;
      repeat (2) @(negedge clk_in);
      check_eq("rst_pwm", 32'(pwm_out), 0);
      check_eq("rst_ps", 32'(period_start), 0);
      check_eq("rst_duty", 32'(duty_active), 0);
      check_eq("rst_rdy", 32'(duty_ready), 1);

      // Release with div_clk high and enable on: no step may be taken.
      reset = 1'b0;
      en    = 1'b1;
      repeat (3) @(negedge clk_in);
      check_eq("rel_cnt", 32'(dut.cnt), 0);
      check_eq("rel_pwm", 32'(pwm_out), 0);
      check_eq("rel_ps", 32'(period_start), 0);
      check_eq("rel_rdy", 32'(duty_ready), 1);

      en    = 1'b0;
      e_cnt = 0;
      accept("acc3_en0", 3);

      @(negedge clk_in);
      en = 1'b1;
      push("en_rise", 1, 1'b0);
      ps_seen = 0;
      for (int i = 0; i < 20; i++) div_rise("run3");
      check_eq("ps_count", 32'(ps_seen), 2);

      for (int i = 0; i < 3; i++) div_rise("pre7");
      accept("acc7", 7);
      for (int i = 0; i < 17; i++) div_rise("run7");

      accept("acc15", 15);
      for (int i = 0; i < 20; i++) div_rise("full");
      check_eq("clamp_duty", 32'(duty_active), 10);

      accept("acc0", 0);
      for (int i = 0; i < 20; i++) div_rise("zero");

      for (int i = 0; i < 9; i++) div_rise("to_wrap");
      div_rise("wrap_acc", 5);
      check_eq("wrap_acc_hold", 32'(duty_active), 0);
      for (int i = 0; i < 10; i++) div_rise("run5");
      check_eq("wrap_acc_apply", 32'(duty_active), 5);

      for (int i = 0; i < 2; i++) div_rise("pre_rst");
      accept("acc4", 4);
      @(negedge clk_in);
      check_eq("pre_rst_pwm", 32'(pwm_out), 1);
      check_eq("pre_rst_rdy", 32'(duty_ready), 0);
      #2 reset = 1'b1;
      #1;
      check_eq("async_pwm", 32'(pwm_out), 0);
      check_eq("async_duty", 32'(duty_active), 0);
      check_eq("async_rdy", 32'(duty_ready), 1);
      check_eq("async_ps", 32'(period_start), 0);
      e_cnt    = 0;
      e_duty   = 0;
      e_shadow = 0;
      e_pend   = 0;
      repeat (2) @(negedge clk_in);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) div_rise("post_rst");
      check_eq("post_rst_duty", 32'(duty_active), 0);

      repeat (3) @(negedge clk_in);
      check_eq("sb_drain", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
